// File: rtl/ula_ctrl_if.sv
// ula_ctrl_if -- command and response channels of the ula_ctrl front-end.
//
// Command channel (valid/ready), producer -> ula_ctrl:
//   cmd_valid, cmd_op[2:0], cmd_a[W-1:0], cmd_b[W-1:0], cmd_acc  / cmd_ready back
// Response channel (valid/ready), ula_ctrl -> consumer:
//   rsp_valid, rsp_r[W-1:0], rsp_zero, rsp_err  / rsp_ready back
//
// slave  : the ula_ctrl side (accepts commands, produces responses)
// master : the command source / response sink side
interface ula_ctrl_if #(
  parameter int W = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_acc;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_r;
  logic         rsp_zero;
  logic         rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_r, rsp_zero, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_r, rsp_zero, rsp_err
  );
endinterface

// File: rtl/ula_ctrl.sv
// ula_ctrl -- sequential command front-end for the combinational W-bit ula ALU.
//
// A command is accepted in IDLE, its operands are held on the ALU inputs for
// one EXEC cycle, the ALU result is captured and then offered on the response
// channel in RESP until the consumer takes it. One command per 3 cycles at best.
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   bus           ula_ctrl_if.slave: command and response handshakes
//   o_ula_a/b     operands driven to the ALU
//   o_ula_op      opcode driven to the ALU (110/111 are invalid)
//   i_ula_r       ALU result
//   i_ula_zero    ALU zero flag
//   o_acc         accumulator (0 when the accumulator is compiled out)
//   o_done_cnt    count of completed responses, wraps silently
//
// Build option: define ULA_CTRL_ACC_EN to include the accumulator. Then
// cmd_acc selects the accumulator as operand A, and every valid opcode loads
// its result into it. Without the macro cmd_acc is ignored and o_acc is 0.
module ula_ctrl #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  ula_ctrl_if.slave     bus,
  output logic [W-1:0]  o_ula_a,
  output logic [W-1:0]  o_ula_b,
  output logic [2:0]    o_ula_op,
  input  logic [W-1:0]  i_ula_r,
  input  logic          i_ula_zero,
  output logic [W-1:0]  o_acc,
  output logic [CW-1:0] o_done_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_cmd_ready;
  logic          w_rsp_valid;
  logic          w_accept;
  logic          w_rsp_hs;
  logic          w_exec;
  logic          w_op_invalid;
  logic [W-1:0]  w_opa;

  logic [W-1:0]  r_ula_a;
  logic [W-1:0]  r_ula_b;
  logic [2:0]    r_ula_op;
  logic [W-1:0]  r_rsp_r;
  logic          r_rsp_zero;
  logic          r_rsp_err;
  logic [CW-1:0] r_done_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Handshake outputs depend on state only; cmd_valid/rsp_ready steer only
  // the next state and register enables.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_accept    = 1'b0;
    w_rsp_hs    = 1'b0;
    w_exec      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_op_invalid = r_ula_op[2] & r_ula_op[1];

`ifdef ULA_CTRL_ACC_EN
  logic [W-1:0] r_acc;

  assign w_opa = bus.cmd_acc ? r_acc : bus.cmd_a;

  // Every valid opcode, eq included, chains its result into the accumulator.
  always_ff @(posedge clk) begin
    if (rst)                         r_acc <= '0;
    else if (w_exec && !w_op_invalid) r_acc <= i_ula_r;
  end

  assign o_acc = r_acc;
`else
  logic w_unused_cmd_acc;

  assign w_unused_cmd_acc = bus.cmd_acc;
  assign w_opa            = bus.cmd_a;
  assign o_acc            = '0;
`endif

  // Operands are loaded only at the accept edge and otherwise hold, so the
  // ALU sees stable inputs through EXEC and keeps them while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ula_a    <= '0;
      r_ula_b    <= '0;
      r_ula_op   <= 3'b000;
      r_rsp_r    <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_ula_a  <= w_opa;
        r_ula_b  <= bus.cmd_b;
        r_ula_op <= bus.cmd_op;
      end
      if (w_exec) begin
        if (w_op_invalid) begin
          r_rsp_r    <= '0;
          r_rsp_zero <= 1'b1;
          r_rsp_err  <= 1'b1;
        end else begin
          r_rsp_r    <= i_ula_r;
          r_rsp_zero <= i_ula_zero;
          r_rsp_err  <= 1'b0;
        end
      end
      if (w_rsp_hs) r_done_cnt <= r_done_cnt + CW'(1);
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_r     = r_rsp_r;
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.rsp_err   = r_rsp_err;
  assign o_ula_a       = r_ula_a;
  assign o_ula_b       = r_ula_b;
  assign o_ula_op      = r_ula_op;
  assign o_done_cnt    = r_done_cnt;

endmodule

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl -- bench for ula_ctrl with a behavioural stand-in for the ula ALU.
// Directed table of commands with hand-computed results, reset corner cases,
// then randomized commands checked against a reference model of the command
// semantics (plain arithmetic plus an accumulator and a done counter).
module tb_ula_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;
`ifdef ULA_CTRL_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ula_ctrl_if #(.W(W)) bus();

  logic [W-1:0]  ula_a, ula_b, ula_r, acc;
  logic [2:0]    ula_op;
  logic          ula_zero;
  logic [CW-1:0] done_cnt;

  ula_ctrl #(.W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_ula_a    (ula_a),
    .o_ula_b    (ula_b),
    .o_ula_op   (ula_op),
    .i_ula_r    (ula_r),
    .i_ula_zero (ula_zero),
    .o_acc      (acc),
    .o_done_cnt (done_cnt)
  );

  // ALU stand-in; invalid opcodes deliberately produce a nonzero result with
  // zero=0 so that the block must override them.
  always_comb begin
    case (ula_op)
      3'd0:    ula_r = ula_a + ula_b;
      3'd1:    ula_r = ula_a - ula_b;
      3'd2:    ula_r = ula_a & ula_b;
      3'd3:    ula_r = ula_a | ula_b;
      3'd4:    ula_r = ula_a ^ ula_b;
      3'd5:    ula_r = (ula_a == ula_b) ? 4'd1 : 4'd0;
      default: ula_r = ~(ula_a ^ ula_b) | 4'b0001;
    endcase
    ula_zero = (ula_r == 4'd0);
  end

  int n_checks = 0;
  int n_pass   = 0;
  int m_acc    = 0;
  int m_done   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void ref_cmd(input int op, input int a, input int b,
                                  output int r, output int z, output int e);
    e = 0;
    case (op)
      0:       r = (a + b) % 16;
      1:       r = (a - b + 16) % 16;
      2:       r = a & b;
      3:       r = a | b;
      4:       r = a ^ b;
      5:       r = (a == b) ? 1 : 0;
      default: begin r = 0; e = 1; end
    endcase
    z = (r == 0) ? 1 : 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_acc  = 0;
    m_done = 0;
  endtask

  // One complete command with protocol checks at every cycle; the response is
  // held off for 'stall' cycles while a stray cmd_valid is presented.
  task automatic exec_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic sel, input int stall,
                          output logic [3:0] o_r, output logic o_z, output logic o_e,
                          output logic [3:0] o_acc);
    int ea, er, ez, ee;
    ea = (ACC_EN && sel) ? m_acc : int'(a);
    ref_cmd(int'(op), ea, int'(b), er, ez, ee);
    @(negedge clk);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_acc   = sel;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_a     = 4'($urandom);
    bus.cmd_b     = 4'($urandom);
    bus.cmd_acc   = 1'($urandom);
    @(negedge clk);
    chk("exec_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("exec_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("exec_ula_a", 32'(ula_a), ea);
    chk("exec_ula_b", 32'(ula_b), 32'(b));
    chk("exec_ula_op", 32'(ula_op), 32'(op));
    @(posedge clk); #1;
    for (int k = 0; k < stall; k++) begin
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("stall_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("stall_rsp_r", 32'(bus.rsp_r), er);
      chk("stall_rsp_zero", 32'(bus.rsp_zero), ez);
      chk("stall_rsp_err", 32'(bus.rsp_err), ee);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rsp_r", 32'(bus.rsp_r), er);
    chk("rsp_zero", 32'(bus.rsp_zero), ez);
    chk("rsp_err", 32'(bus.rsp_err), ee);
    o_r = bus.rsp_r;
    o_z = bus.rsp_zero;
    o_e = bus.rsp_err;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    m_done = (m_done + 1) % (1 << CW);
    if (ACC_EN && ee == 0) m_acc = er;
    @(negedge clk);
    chk("post_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("post_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("post_done_cnt", 32'(done_cnt), m_done);
    chk("post_acc", 32'(acc), m_acc);
    chk("post_ula_a_hold", 32'(ula_a), ea);
    o_acc = acc;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic [3:0] r;
    logic       z;
    logic       e;
    logic [3:0] acc;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [3:0] got_r, got_acc;
    logic       got_z, got_e;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 4'd0;
    bus.cmd_b     = 4'd0;
    bus.cmd_acc   = 1'b0;
    bus.rsp_ready = 1'b0;

    //          op    a      b      sel   r      z     e     acc after
    tbl[0]  = '{3'd0, 4'd3,  4'd2,  1'b0, 4'd5,  1'b0, 1'b0, ACC_EN ? 4'd5  : 4'd0};
    tbl[1]  = '{3'd1, 4'd7,  4'd5,  1'b0, 4'd2,  1'b0, 1'b0, ACC_EN ? 4'd2  : 4'd0};
    tbl[2]  = '{3'd5, 4'd9,  4'd9,  1'b0, 4'd1,  1'b0, 1'b0, ACC_EN ? 4'd1  : 4'd0};
    tbl[3]  = '{3'd7, 4'd1,  4'd1,  1'b0, 4'd0,  1'b1, 1'b1, ACC_EN ? 4'd1  : 4'd0};
    tbl[4]  = '{3'd5, 4'd9,  4'd8,  1'b0, 4'd0,  1'b1, 1'b0, 4'd0};
    tbl[5]  = '{3'd0, 4'd3,  4'd2,  1'b0, 4'd5,  1'b0, 1'b0, ACC_EN ? 4'd5  : 4'd0};
    tbl[6]  = '{3'd0, 4'd0,  4'd4,  1'b1, ACC_EN ? 4'd9 : 4'd4, 1'b0, 1'b0, ACC_EN ? 4'd9 : 4'd0};
    tbl[7]  = '{3'd6, 4'd2,  4'd3,  1'b1, 4'd0,  1'b1, 1'b1, ACC_EN ? 4'd9  : 4'd0};
    tbl[8]  = '{3'd2, 4'd12, 4'd10, 1'b0, 4'd8,  1'b0, 1'b0, ACC_EN ? 4'd8  : 4'd0};
    tbl[9]  = '{3'd3, 4'd12, 4'd3,  1'b0, 4'd15, 1'b0, 1'b0, ACC_EN ? 4'd15 : 4'd0};
    tbl[10] = '{3'd4, 4'd15, 4'd15, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0};
    tbl[11] = '{3'd0, 4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0, 4'd0};
    tbl[12] = '{3'd1, 4'd0,  4'd1,  1'b0, 4'd15, 1'b0, 1'b0, ACC_EN ? 4'd15 : 4'd0};
    tbl[13] = '{3'd0, 4'd7,  4'd1,  1'b1, ACC_EN ? 4'd0 : 4'd8, ACC_EN ? 1'b1 : 1'b0, 1'b0, 4'd0};

    do_reset();
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_r", 32'(bus.rsp_r), 0);
    chk("rst_rsp_zero", 32'(bus.rsp_zero), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_ula_a", 32'(ula_a), 0);
    chk("rst_ula_b", 32'(ula_b), 0);
    chk("rst_ula_op", 32'(ula_op), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_done_cnt", 32'(done_cnt), 0);

    for (int i = 0; i < 14; i++) begin
      exec_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sel, (i == 0) ? 5 : 0,
               got_r, got_z, got_e, got_acc);
      chk($sformatf("tbl%0d_r", i), 32'(got_r), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_zero", i), 32'(got_z), 32'(tbl[i].z));
      chk($sformatf("tbl%0d_err", i), 32'(got_e), 32'(tbl[i].e));
      chk($sformatf("tbl%0d_acc", i), 32'(got_acc), 32'(tbl[i].acc));
    end

    // Reset while the command is in EXEC: the command is dropped.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 4'd1;
    bus.cmd_b     = 4'd1;
    bus.cmd_acc   = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstexec_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rstexec_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rstexec_done_cnt", 32'(done_cnt), 0);
    chk("rstexec_ula_a", 32'(ula_a), 0);
    chk("rstexec_acc", 32'(acc), 0);
    m_acc  = 0;
    m_done = 0;

    // A command completes, then reset arrives in RESP together with rsp_ready.
    exec_cmd(3'd0, 4'd2, 4'd2, 1'b0, 0, got_r, got_z, got_e, got_acc);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd7;
    bus.cmd_a     = 4'd3;
    bus.cmd_b     = 4'd3;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rstresp_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rstresp_done_cnt", 32'(done_cnt), 0);
    chk("rstresp_rsp_err", 32'(bus.rsp_err), 0);
    chk("rstresp_rsp_zero", 32'(bus.rsp_zero), 0);
    m_acc  = 0;
    m_done = 0;

    // Randomized commands; enough of them to wrap the done counter.
    for (int n = 0; n < 270; n++) begin
      exec_cmd(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom),
               $urandom_range(0, 2), got_r, got_z, got_e, got_acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ula_ctrl.md
# ula_ctrl

Sequential command front-end for the 4-bit `ula` ALU. It drives the ALU's `a`, `b`, `op` inputs and consumes its `r`, `zero` outputs. Commands arrive over a valid/ready handshake. The block issues each command to the combinational ALU, captures the result, and returns it over a valid/ready response channel. An optional accumulator lets commands chain on the previous result.

## Interface
- `W`, 4, operand/result width (matches `ula`)
- `CW`, 8, width of the completed-command counter
- `clk`  in  1  clock, rising-edge
- `rst`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_op`  in  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 eq; 110/111 invalid
- `cmd_a`  in  W  operand A
- `cmd_b`  in  W  operand B
- `cmd_acc`  in  1  use accumulator as operand A instead of `cmd_a`
- `ula_a`  out  W  to ALU `a`
- `ula_b`  out  W  to ALU `b`
- `ula_op`  out  3  to ALU `op`
- `ula_r`  in  W  from ALU `r`
- `ula_zero`  in  1  from ALU `zero`
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_r`  out  W  captured result
- `rsp_zero`  out  1  captured zero flag
- `rsp_err`  out  1  opcode was invalid
- `acc`  out  W  accumulator value
- `done_cnt`  out  CW  count of completed responses

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch `ula_op`<=`cmd_op` and `ula_b`<=`cmd_b`.
  - Latch `ula_a`<=(`cmd_acc` ? `acc` : `cmd_a`).
  - Go to EXEC.
- EXEC:
  - `cmd_ready`=0. ALU inputs are stable for the whole cycle.
  - At the end of the cycle, capture `rsp_r`<=`ula_r` and `rsp_zero`<=`ula_zero`.
  - If `ula_op` is 110/111: `rsp_r`<=0, `rsp_zero`<=1, `rsp_err`<=1. ALU outputs are ignored.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1 and `cmd_ready`=0.
  - `rsp_r`, `rsp_zero`, `rsp_err` stay stable until handshake.
  - On `rsp_valid`&&`rsp_ready`: `done_cnt`++ and go to IDLE.
- Accumulator:
  - `acc`<=`rsp_r` at the end of EXEC, only for a valid opcode.
  - Invalid opcode leaves `acc` unchanged.
  - The eq opcode (101) also updates `acc` with its `r`.
- `ula_a`/`ula_b`/`ula_op` hold their last values while in IDLE.
- `done_cnt` wraps from 2^CW-1 to 0 with no flag.
- `cmd_valid` is ignored outside IDLE. Command fields are sampled only at the accept edge.

## Timing
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_r`=0, `rsp_zero`=0, `rsp_err`=0, `ula_a`=0, `ula_b`=0, `ula_op`=000, `acc`=0, `done_cnt`=0.
- Latency: command accepted at edge N. ALU is evaluated in cycle N+1. `rsp_valid`=1 from edge N+2.
- Zero-wait throughput: accept at N, response handshake at N+2, IDLE at N+3, so one command per 3 cycles.
- `cmd_ready` is combinational from state only. There is no combinational path from `cmd_valid` or `rsp_ready` to any output.
- Backpressure: `rsp_ready` held low keeps the block in RESP indefinitely with all response outputs frozen.
- Reset mid-operation, in EXEC or RESP: the pending command and response are discarded with no `done_cnt` increment. All outputs take reset values at the next edge.
- `rst` has priority over every handshake in the same cycle.

## Configuration
- `ULA_CTRL_ACC_EN` defined:
  - Accumulator register present.
  - `cmd_acc` selects `acc` as operand A.
  - `acc` updates as above.
- Not defined:
  - No accumulator register.
  - `cmd_acc` is ignored and operand A is always `cmd_a`.
  - `acc` output tied to 0.

## Test plan
- Reset, then add: `cmd_op`=000, a=3, b=2, accepted at edge N.
  - `ula_a`=3, `ula_b`=2 during cycle N+1.
  - `rsp_valid`=1 at N+2 with `rsp_r`=5, `rsp_zero`=0, `rsp_err`=0.
  - `done_cnt`=1 after handshake.
- Sub 7-5 gives `rsp_r`=2, `rsp_zero`=0.
- Eq with a=9, b=9 and with a=9, b=8: `rsp_r` and `rsp_zero` equal the ALU outputs exactly.
- Invalid op 111, a=1, b=1: `rsp_err`=1, `rsp_r`=0, `rsp_zero`=1, `acc` unchanged.
- Accumulator (`ULA_CTRL_ACC_EN`): add a=3, b=2 gives `acc`=5. Then `cmd_acc`=1, add, `cmd_a`=0, b=4.
  - `ula_a`=5 and `rsp_r`=9, `acc`=9.
  - Without the macro, the same sequence gives `rsp_r`=4 and `acc`=0.
- Backpressure and reset:
  - `rsp_ready`=0 for 5 cycles: `rsp_*` stable, `cmd_ready`=0, a second `cmd_valid` is ignored.
  - `rst` pulse in EXEC: next cycle `rsp_valid`=0, `cmd_ready`=1, `done_cnt` unchanged from before reset (0).
